mmu_act_feeder: RTL and testbench

- Upstream stage of the systolic matrix-multiply array; drives the west edge of the PE grid.
- Buffers activation row-vectors from the on-chip buffer in a small FIFO.
- Issues a programmed number of vectors and skews them diagonally: array row r sees each vector element r cycles after row 0.
- Generates the per-row en consumed by each PE row, so that psums meet correctly in every column.

---
 rtl/mmu_pkg.sv | 20 ++
 rtl/mmu_vec_fifo.sv | 55 +++++
 rtl/mmu_act_feeder.sv | 132 +++++++++++++
 tb/tb_mmu_act_feeder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and constants for the matrix-multiply unit: default widths,
// the activation feeder state encoding and the partial-sum width helper.
package mmu_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ROWS       = 4;
    localparam int PSUM_WIDTH     = 2 * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    function automatic int psum_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/mmu_vec_fifo.sv
// Synchronous vector FIFO with show-ahead read data. A push is refused when
// full even if a pop happens in the same cycle (no bypass).
module mmu_vec_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/mmu_act_feeder.sv
// West-edge activation feeder: buffers row-vectors, issues a programmed count
// of them and skews element r by r cycles so partial sums align per column.
module mmu_act_feeder
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         vec_valid,
    output logic                         vec_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]   vec_data,
    input  logic                         start,
    input  logic [CNT_W-1:0]             num_vecs,
    output logic                         busy,
    output logic                         done,
    output logic [ROWS-1:0]              row_en,
    output logic [ROWS*DATA_WIDTH-1:0]   row_data,
    output feeder_state_e                dbg_state,
    output logic [$clog2(DEPTH):0]       dbg_fifo_count
);

    localparam int DRW = (ROWS > 1) ? $clog2(ROWS) : 1;

    feeder_state_e               r_state, w_state_nxt;
    logic [CNT_W-1:0]            r_remaining, w_remaining_nxt;
    logic [DRW-1:0]              r_drain_cnt, w_drain_cnt_nxt;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_pop;
    logic [ROWS*DATA_WIDTH-1:0]  w_head;

    // Upstream handshake: a vector transfers on a cycle where vec_valid and
    // vec_ready are both high; vec_ready depends only on FIFO occupancy.
    mmu_vec_fifo #(
        .WIDTH (ROWS*DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (vec_valid),
        .i_wdata (vec_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (dbg_fifo_count)
    );

    assign vec_ready = !w_full;
    assign w_pop     = (r_state == STREAM) && !w_empty && (r_remaining != '0);
    assign busy      = (r_state == STREAM) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (num_vecs != '0) begin
                        w_remaining_nxt = num_vecs;
                        w_state_nxt     = STREAM;
                    end else begin
                        w_state_nxt     = DONE;
                    end
                end
            end
            STREAM: begin
                if (w_pop) begin
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        if (ROWS == 1) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt     = DRAIN;
                            w_drain_cnt_nxt = DRW'(ROWS-1);
                        end
                    end
                end
            end
            DRAIN: begin
                // Holds until the last element reaches the bottom row.
                if (r_drain_cnt == '0) w_state_nxt = DONE;
                else                   w_drain_cnt_nxt = r_drain_cnt - 1'b1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Triangular skew: row r keeps r+1 registers, stage 0 captures the pop.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        logic [gr:0]           r_en;
        logic [DATA_WIDTH-1:0] r_dat [gr+1];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_en <= '0;
                for (int k = 0; k <= gr; k++) r_dat[k] <= '0;
            end else begin
                r_en[0]  <= w_pop;
                r_dat[0] <= w_pop ? w_head[gr*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= gr; k++) begin
                    r_en[k]  <= r_en[k-1];
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end

        assign row_en[gr]                               = r_en[gr];
        assign row_data[gr*DATA_WIDTH +: DATA_WIDTH]    = r_dat[gr];
    end

endmodule

// File: tb/tb_mmu_act_feeder.sv
// Directed bench for mmu_act_feeder (ROWS=4, 16-bit data, 8-deep FIFO):
// skew, bubbles, FIFO full/wrap, zero count, ignored start, async reset.
module tb_mmu_act_feeder;
    import mmu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vec_valid;
    logic        vec_ready;
    logic [63:0] vec_data;
    logic        start;
    logic [15:0] num_vecs;
    logic        busy;
    logic        done;
    logic [3:0]  row_en;
    logic [63:0] row_data;
    feeder_state_e dbg_state;
    logic [3:0]  dbg_fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];

    // per-pass stimulus tables, filled before each run_pass call
    int          pop_t   [8];
    int          late_t  [8];
    logic [63:0] late_v  [8];
    int          n_late  = 0;
    int          ign_t   = -1;

    mmu_act_feeder #(
        .DATA_WIDTH (16),
        .ROWS       (4),
        .DEPTH      (8),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .vec_valid      (vec_valid),
        .vec_ready      (vec_ready),
        .vec_data       (vec_data),
        .start          (start),
        .num_vecs       (num_vecs),
        .busy           (busy),
        .done           (done),
        .row_en         (row_en),
        .row_data       (row_data),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkv(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // driver tasks
    task automatic push_vec(input logic [63:0] v);
        vec_valid = 1'b1;
        vec_data  = v;
        step();
        vec_valid = 1'b0;
        exp_q.push_back(v);
        check("push vec_ready", 64'(vec_ready), 64'(exp_q.size() < 8));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " row_en"},    64'(row_en), 64'd0);
        check({tag, " row_data"},  row_data,    64'd0);
        check({tag, " busy"},      64'(busy),   64'd0);
        check({tag, " done"},      64'(done),   64'd0);
        check({tag, " vec_ready"}, 64'(vec_ready), 64'd1);
    endtask

    // Starts a pass and checks every cycle up to one past the done pulse.
    // pop_t lists the clock edge (counted from the start edge) of each pop.
    task automatic run_pass(input string tag, input int n_vec, input int n_pop, input int done_t);
        logic [63:0] vec_at [32];
        logic        popv   [32];
        logic [3:0]  e_en;
        logic [63:0] e_dat;
        logic [63:0] pv;
        logic        pushed;
        for (int i = 0; i < 32; i++) begin
            popv[i]   = 1'b0;
            vec_at[i] = '0;
        end
        start    = 1'b1;
        num_vecs = 16'(n_vec);
        step();
        start    = 1'b0;
        for (int t = 0; t <= done_t + 1; t++) begin
            pushed = 1'b0;
            pv     = '0;
            if (t > 0) begin
                for (int i = 0; i < n_late; i++) begin
                    if (late_t[i] == t) begin
                        vec_valid = 1'b1;
                        vec_data  = late_v[i];
                        pv        = late_v[i];
                        pushed    = 1'b1;
                    end
                end
                if (t == ign_t) begin
                    start    = 1'b1;
                    num_vecs = 16'd5;
                end
                step();
                vec_valid = 1'b0;
                start     = 1'b0;
            end
            for (int i = 0; i < n_pop; i++) begin
                if (pop_t[i] == t) begin
                    popv[t]   = 1'b1;
                    vec_at[t] = exp_q.pop_front();
                end
            end
            if (pushed) exp_q.push_back(pv);
            e_en  = '0;
            e_dat = '0;
            for (int r = 0; r < 4; r++) begin
                if (t >= r && popv[t-r]) begin
                    e_en[r]         = 1'b1;
                    e_dat[r*16 +: 16] = vec_at[t-r][r*16 +: 16];
                end
            end
            check($sformatf("%s t%0d row_en", tag, t),    64'(row_en),    64'(e_en));
            check($sformatf("%s t%0d row_data", tag, t),  row_data,       e_dat);
            check($sformatf("%s t%0d done", tag, t),      64'(done),      64'(t == done_t));
            check($sformatf("%s t%0d busy", tag, t),      64'(busy),      64'(t < done_t));
            check($sformatf("%s t%0d vec_ready", tag, t), 64'(vec_ready), 64'(exp_q.size() < 8));
        end
        n_late = 0;
        ign_t  = -1;
    endtask

    initial begin
        rstn      = 1'b0;
        vec_valid = 1'b0;
        vec_data  = '0;
        start     = 1'b0;
        num_vecs  = '0;
        step();
        step();
        check_idle_outputs("reset");
        rstn = 1'b1;
        step();

        // basic skew: pops at edges 1,2; row 3 shows 8 at t=5, done at t=6
        push_vec(mkv(1, 2, 3, 4));
        push_vec(mkv(5, 6, 7, 8));
        pop_t[0] = 1; pop_t[1] = 2;
        run_pass("skew", 2, 2, 6);

        // underflow: 2nd/3rd vectors arrive late, giving a 2-cycle bubble
        push_vec(mkv(16'h11, 16'h12, 16'h13, 16'h14));
        late_t[0] = 3; late_v[0] = mkv(16'h21, 16'h22, 16'h23, 16'h24);
        late_t[1] = 4; late_v[1] = mkv(16'h31, 16'h32, 16'h33, 16'h34);
        n_late = 2;
        pop_t[0] = 1; pop_t[1] = 4; pop_t[2] = 5;
        run_pass("bubble", 3, 3, 9);

        // FIFO full and pointer wrap
        for (int k = 0; k < 8; k++)
            push_vec(mkv(16'h100 + k, 16'h200 + k, 16'h300 + k, 16'h400 + k));
        vec_valid = 1'b1;
        vec_data  = mkv(16'hdead, 16'hdead, 16'hdead, 16'hdead);
        step();
        check("full held off", 64'(vec_ready), 64'd0);
        vec_valid = 1'b0;
        for (int k = 0; k < 8; k++) pop_t[k] = k + 1;
        run_pass("full", 8, 8, 12);

        // zero count: done right after the start edge, FIFO keeps its entry
        push_vec(mkv(16'h501, 16'h502, 16'h503, 16'h504));
        run_pass("zero", 0, 0, 0);
        check("zero fifo count", 64'(dbg_fifo_count), 64'd1);

        // start while busy is ignored
        for (int k = 0; k < 4; k++)
            push_vec(mkv(16'h600 + k, 16'h700 + k, 16'h800 + k, 16'h900 + k));
        ign_t = 2;
        pop_t[0] = 1; pop_t[1] = 2; pop_t[2] = 3;
        run_pass("ignstart", 3, 3, 7);
        check("ignstart leftover", 64'(dbg_fifo_count), 64'd2);

        // reset during DRAIN: outputs clear without a clock edge
        start    = 1'b1;
        num_vecs = 16'd1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre-reset row_en", 64'(row_en), 64'b0010);
        #2;
        rstn = 1'b0;
        #1;
        check_idle_outputs("async reset");
        step();
        rstn = 1'b1;
        exp_q.delete();
        step();
        check("post-reset fifo count", 64'(dbg_fifo_count), 64'd0);
        push_vec(mkv(16'hA1, 16'hA2, 16'hA3, 16'hA4));
        pop_t[0] = 1;
        run_pass("after reset", 1, 1, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (compared %0d)", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
